// File: rtl/block_writer_if.sv
// Command and byte-stream bundle for block_writer: command port in, ASCII bytes out,
// plus the nesting-depth status the downstream checker verdict is predicted from.
interface block_writer_if #(
    parameter int DEPTH_W = 32
);
    logic               cmd_valid;
    logic [1:0]         cmd;
    logic               cmd_ready;
    logic [7:0]         out_char;
    logic               out_valid;
    logic               out_ready;
    logic [DEPTH_W-1:0] depth;
    logic               err;
    logic               balanced;

    modport master (
        output cmd_valid, cmd, out_ready,
        input  cmd_ready, out_char, out_valid, depth, err, balanced
    );

    modport slave (
        input  cmd_valid, cmd, out_ready,
        output cmd_ready, out_char, out_valid, depth, err, balanced
    );
endinterface

// File: rtl/block_writer.sv
// Serializes OPEN/CLOSE/SPACE commands into " begin"/" end"/" " bytes, one byte per
// out handshake; first byte visible the cycle after accept; stalls indefinitely on !out_ready.
module block_writer #(
    parameter int DEPTH_W = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    block_writer_if.slave bus
);
    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    localparam logic [1:0] C_OPEN  = 2'b00;
    localparam logic [1:0] C_CLOSE = 2'b01;
    localparam logic [1:0] C_SPACE = 2'b10;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_idx;
    logic [1:0]         r_cmd;
    logic [7:0]         r_char;
    logic               r_valid;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_err;

    logic               w_accept;
    logic               w_emit_cmd;
    logic               w_fire;
    logic               w_last;
    logic [2:0]         w_last_idx;
    logic [2:0]         w_idx_nxt;

    function automatic logic [7:0] kw_byte(input logic [1:0] c, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h20;
        if (c == C_OPEN) begin
            case (i)
                3'd1:    b = 8'h62;
                3'd2:    b = 8'h65;
                3'd3:    b = 8'h67;
                3'd4:    b = 8'h69;
                3'd5:    b = 8'h6e;
                default: b = 8'h20;
            endcase
        end else if (c == C_CLOSE) begin
            case (i)
                3'd1:    b = 8'h65;
                3'd2:    b = 8'h6e;
                3'd3:    b = 8'h64;
                default: b = 8'h20;
            endcase
        end
        return b;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_emit_cmd = (bus.cmd != 2'b11);
    assign w_fire     = r_valid && bus.out_ready;
    assign w_idx_nxt  = r_idx + 3'd1;

    always_comb begin
        w_last_idx = 3'd0;
        case (r_cmd)
            C_OPEN:  w_last_idx = 3'd5;
            C_CLOSE: w_last_idx = 3'd3;
            default: w_last_idx = 3'd0;
        endcase
    end

    assign w_last = (r_idx == w_last_idx);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Reserved code 2'b11 is consumed in IDLE without leaving it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_emit_cmd) w_next = S_EMIT;
            S_EMIT: if (w_fire && w_last)       w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (r_state == S_IDLE);
        bus.out_char  = r_char;
        bus.out_valid = r_valid;
        bus.depth     = r_depth;
        bus.err       = r_err;
        bus.balanced  = (r_depth == '0) && !r_err;
    end

    // Depth and err move at accept time; errored commands still emit their text.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx   <= 3'd0;
            r_cmd   <= C_SPACE;
            r_char  <= 8'h00;
            r_valid <= 1'b0;
            r_depth <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            if (bus.cmd == C_OPEN) begin
                if (r_depth == '1) r_err <= 1'b1;
                else               r_depth <= r_depth + 1'b1;
            end else if (bus.cmd == C_CLOSE) begin
                if (r_depth == '0) r_err <= 1'b1;
                else               r_depth <= r_depth - 1'b1;
            end
            if (w_emit_cmd) begin
                r_cmd   <= bus.cmd;
                r_char  <= 8'h20;
                r_valid <= 1'b1;
                r_idx   <= 3'd0;
            end
        end else if (r_state == S_EMIT && w_fire) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx  <= w_idx_nxt;
                r_char <= kw_byte(r_cmd, w_idx_nxt);
            end
        end
    end
endmodule
